// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage: PC, IF/ID register, stall/flush/redirect/halt control
module if_fetch_stage #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] HALT_INSTR = {DATA_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_instr,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  halted
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;

  // Memory is asynchronous, so the PC register addresses it directly.
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
      halted   <= 1'b0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      if_valid <= 1'b0;
      state    <= RUN;
      halted   <= 1'b0;
    end else if (flush) begin
      // PC holds so the squashed slot's instruction is refetched.
      if_valid <= 1'b0;
    end else if (!stall) begin
      case (state)
        RUN: begin
          if_instr <= imem_instr;
          if_pc    <= pc;
          if_valid <= 1'b1;
          if (imem_instr == HALT_INSTR) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else begin
            pc <= pc + 1'b1;
          end
        end
        HALTED: begin
          if_valid <= 1'b0;
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the asynchronous instruction memory.
- Owns the program counter and drives the memory word address.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles decode-stage stall, pipeline flush, branch/jump redirect, and a halt instruction that freezes fetch until redirected.

Parameters:
- ADDR_WIDTH, 8, PC / instruction-memory word-address width.
- DATA_WIDTH, 16, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- HALT_INSTR, 16'hFFFF, encoding that stops fetch once accepted into IF/ID.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  decode not ready; hold PC and IF/ID.
- flush  input  1  invalidate IF/ID content.
- redirect_valid  input  1  load new PC (branch/jump taken).
- redirect_pc  input  ADDR_WIDTH  redirect target word address.
- imem_addr  output  ADDR_WIDTH  word address to instruction memory; equals pc combinationally.
- imem_instr  input  DATA_WIDTH  instruction read asynchronously from imem_addr in the same cycle.
- if_valid  output  1  IF/ID register holds a live instruction.
- if_instr  output  DATA_WIDTH  IF/ID instruction.
- if_pc  output  ADDR_WIDTH  address of if_instr.
- halted  output  1  fetch frozen by HALT_INSTR.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, halted=0, state=RUN.
  - Reset in mid-stall or mid-halt discards everything.
  - First fetch occurs on the first rising edge after rst_n deasserts.
- Data path:
  - imem_addr=pc, with no register in between.
  - Fetch latency is one cycle: the instruction at pc appears on if_instr after the next edge.
- States: RUN and HALTED. halted=1 exactly when the state is HALTED.
- Per-edge priority, highest first: redirect_valid > flush > stall > state action.
  - redirect_valid=1:
    - pc<=redirect_pc, if_valid<=0, state<=RUN, halted<=0.
    - Applies even when stall=1 or state is HALTED.
    - if_instr and if_pc hold.
  - flush=1 (no redirect):
    - if_valid<=0.
    - pc holds, so the instruction at pc is refetched next cycle.
    - State unchanged.
  - stall=1 (no redirect, no flush): pc, if_valid, if_instr, if_pc and state all hold.
  - RUN, no control inputs:
    - if_instr<=imem_instr, if_pc<=pc, if_valid<=1.
    - If imem_instr==HALT_INSTR: pc holds, state<=HALTED, halted<=1. The halt instruction itself is delivered valid.
    - Otherwise pc<=pc+1, modulo 2^ADDR_WIDTH.
  - HALTED, no control inputs: if_valid<=0; pc, if_instr and if_pc hold.
- Wrap-around: the PC at all-ones wraps to 0 with no flag.
- Flush and stall together: flush wins, so the bubble is inserted.
- Redirect to the current pc is legal and acts as a refetch.
- A HALT_INSTR fetched while stall=1 is not accepted and has no effect until the stall releases.
- Outputs are registered except imem_addr; no combinational path from imem_instr to any output.

Test Plan:
- Reset release, memory holding 0x1111,0x2222,0x3333 at 0..2 → imem_addr 0,1,2,3 on consecutive cycles; if_instr/if_pc = 1111/0, 2222/1, 3333/2; if_valid=1 from the first edge.
- stall high for 3 cycles while if_pc=1 → imem_addr stays 2 and if_instr stays 0x2222 throughout; after release, 0x3333/2 appears on the next edge.
- redirect_valid with redirect_pc=0x40, asserted together with stall=1 → if_valid=0 next cycle; the following edge gives if_pc=0x40 and if_instr=mem[0x40].
- flush alone at pc=5 → one bubble (if_valid=0); next edge gives if_pc=5, so no instruction is skipped.
- HALT_INSTR at address 7 → if_instr=0xFFFF/if_pc=7 valid for one cycle, then if_valid=0, halted=1, imem_addr frozen at 7 for 10+ cycles; redirect to 0 clears halted and fetch resumes.
- PC=0xFF with no control inputs → next imem_addr=0x00; rst_n pulsed low mid-HALTED → outputs return to reset values immediately, without waiting for a clock edge.
